// File: rtl/ctl_pkg.sv
// Control-bundle layout and select encodings shared by the hazard/pipeline logic.
package ctl_pkg;

    localparam int unsigned CTL_BITS = 15;
    localparam int unsigned RADDR_W  = 5;

    localparam int B_LOGIC_EXT  = 14;
    localparam int B_JAL        = 13;
    localparam int B_JMP_HI     = 12;
    localparam int B_JMP_LO     = 11;
    localparam int B_REG_DST    = 10;
    localparam int B_ALU_SRC    = 9;
    localparam int B_MEM_TO_REG = 8;
    localparam int B_REG_WRITE  = 7;
    localparam int B_MEM_READ   = 6;
    localparam int B_MEM_WRITE  = 5;
    localparam int B_BRANCH_NE  = 4;
    localparam int B_BRANCH_EQ  = 3;
    localparam int B_ALU_OP_HI  = 2;
    localparam int B_ALU_OP_LO  = 0;

    localparam logic [CTL_BITS-1:0] CTL_NOP = '0;
    localparam logic [1:0]          JMP_J   = 2'b01;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Youngest writer wins; register 0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic               exm_wr,
        input logic [RADDR_W-1:0] exm_dst,
        input logic               mwb_wr,
        input logic [RADDR_W-1:0] mwb_dst,
        input logic [RADDR_W-1:0] src
    );
        if (exm_wr && (exm_dst != '0) && (exm_dst == src))
            return FWD_EXMEM;
        else if (mwb_wr && (mwb_dst != '0) && (mwb_dst == src))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/ctl_pipe_reg.sv
// Pipeline stage register: async active-low clear, synchronous bubble insert.
module ctl_pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = load_bubble_i ? '0 : d_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            data_q <= '0;
        else
            data_q <= data_d;
    end

    assign q_o = data_q;

endmodule

// File: rtl/control_hazard_pipe.sv
// Carries the decoded control bundle through ID/EX, EX/MEM, MEM/WB and generates
// load-use stall, EX branch/jump flush, PC source and operand forwarding selects.
module control_hazard_pipe
    import ctl_pkg::*;
#(
    parameter int unsigned CTL_W  = 15,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned RA_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid_i,
    input  logic [CTL_W-1:0] id_ctl_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             ex_zero_i,
    output logic [CTL_W-1:0] ex_ctl_o,
    output logic [CTL_W-1:0] mem_ctl_o,
    output logic [REG_W-1:0] ex_write_reg_o,
    output logic             wb_reg_write_o,
    output logic             wb_mem_to_reg_o,
    output logic [REG_W-1:0] wb_write_reg_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic [1:0]       pc_src_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o
);

    localparam int unsigned IDEX_W  = CTL_W + 3 * REG_W;
    localparam int unsigned EXMEM_W = CTL_W + REG_W;
    localparam int unsigned MEMWB_W = 2 + REG_W;

    logic [IDEX_W-1:0]  idex_q;
    logic [EXMEM_W-1:0] exmem_q;
    logic [MEMWB_W-1:0] memwb_q;

    logic [CTL_W-1:0] idex_ctl;
    logic [REG_W-1:0] idex_dst;
    logic [REG_W-1:0] idex_rs;
    logic [REG_W-1:0] idex_rt;
    logic [CTL_W-1:0] exmem_ctl;
    logic [REG_W-1:0] exmem_dst;

    logic [REG_W-1:0] id_dst;
    logic             id_bubble;
    logic             ex_taken;
    logic             ex_jump;
    logic             load_use;

    always_comb begin
        if (id_ctl_i[B_JAL])
            id_dst = REG_W'(RA_REG);
        else if (id_ctl_i[B_REG_DST])
            id_dst = id_rd_i;
        else
            id_dst = id_rt_i;
    end

    assign id_bubble = ~id_valid_i | stall_o | flush_o;

    ctl_pipe_reg #(.W(IDEX_W)) u_idex (
        .clk           (clk),
        .reset         (reset),
        .load_bubble_i (id_bubble),
        .d_i           ({id_ctl_i, id_dst, id_rs_i, id_rt_i}),
        .q_o           (idex_q)
    );

    ctl_pipe_reg #(.W(EXMEM_W)) u_exmem (
        .clk           (clk),
        .reset         (reset),
        .load_bubble_i (1'b0),
        .d_i           ({idex_ctl, idex_dst}),
        .q_o           (exmem_q)
    );

    // Only the write-back controls are needed past MEM.
    ctl_pipe_reg #(.W(MEMWB_W)) u_memwb (
        .clk           (clk),
        .reset         (reset),
        .load_bubble_i (1'b0),
        .d_i           ({exmem_ctl[B_REG_WRITE], exmem_ctl[B_MEM_TO_REG], exmem_dst}),
        .q_o           (memwb_q)
    );

    assign {idex_ctl, idex_dst, idex_rs, idex_rt} = idex_q;
    assign {exmem_ctl, exmem_dst}                 = exmem_q;
    assign {wb_reg_write_o, wb_mem_to_reg_o, wb_write_reg_o} = memwb_q;

    assign ex_ctl_o       = idex_ctl;
    assign mem_ctl_o      = exmem_ctl;
    assign ex_write_reg_o = idex_dst;

    assign ex_taken = (idex_ctl[B_BRANCH_EQ] &  ex_zero_i)
                    | (idex_ctl[B_BRANCH_NE] & ~ex_zero_i);
    assign ex_jump  = (idex_ctl[B_JMP_HI:B_JMP_LO] == JMP_J);
    assign flush_o  = ex_taken | ex_jump;

    always_comb begin
        if (ex_jump)
            pc_src_o = PC_JMP;
        else if (ex_taken)
            pc_src_o = PC_BR;
        else
            pc_src_o = PC_SEQ;
    end

    // A redirect already squashes the dependent instruction, so it overrides the stall.
    assign load_use = idex_ctl[B_MEM_READ] & (idex_rt != '0)
                    & ((idex_rt == id_rs_i) | (idex_rt == id_rt_i));
    assign stall_o  = load_use & id_valid_i & ~flush_o;

    assign fwd_a_o = fwd_sel(exmem_ctl[B_REG_WRITE], exmem_dst,
                             wb_reg_write_o, wb_write_reg_o, idex_rs);
    assign fwd_b_o = fwd_sel(exmem_ctl[B_REG_WRITE], exmem_dst,
                             wb_reg_write_o, wb_write_reg_o, idex_rt);

endmodule
